// File: rtl/key_cmd_scheduler.sv
// rtl/key_cmd_scheduler.sv - buffers debounced key presses and issues them as round-robin key commands
module key_cmd_scheduler #(
    parameter int unsigned HOLDOFF = 12000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] key_pulse,
    input  logic       cmd_ready,
    input  logic       drop_clr,
    output logic       cmd_valid,
    output logic [1:0] cmd_key,
    output logic       busy,
    output logic [2:0] drop
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam bit          HOLD_EN   = (HOLDOFF != 0);
    localparam logic [19:0] HOLD_LOAD = 20'(HOLDOFF == 0 ? 0 : HOLDOFF - 1);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  pending;
    logic [1:0]  ptr;
    logic [19:0] cnt;
    logic        accept;
    logic [2:0]  clr_mask;
    logic [2:0]  drop_set;
    logic [1:0]  winner;

    function automatic logic [1:0] next_idx(input logic [1:0] k);
        return (k == 2'd2) ? 2'd0 : k + 2'd1;
    endfunction

    // First pending key found scanning ptr, ptr+1, ptr+2 (mod 3).
    function automatic logic [1:0] pick(input logic [2:0] p, input logic [1:0] s);
        logic [1:0] c1;
        logic [1:0] c2;
        c1 = next_idx(s);
        c2 = next_idx(c1);
        if (p[s])       return s;
        else if (p[c1]) return c1;
        else            return c2;
    endfunction

    assign accept   = (state == ISSUE) && cmd_ready;
    assign clr_mask = accept ? (3'b001 << cmd_key) : 3'b000;
    // A press arriving while its key is still buffered (and not being drained now) is lost.
    assign drop_set = key_pulse & pending & ~clr_mask;
    assign winner   = pick(pending, ptr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|pending) state_nxt = ISSUE;
            ISSUE:   if (cmd_ready) state_nxt = HOLD_EN ? HOLD : IDLE;
            HOLD:    if (cnt == 20'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_valid = 1'b0;
        busy      = 1'b0;
        if (state == ISSUE) cmd_valid = 1'b1;
        if (state != IDLE)  busy      = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= 3'b000;
            ptr     <= 2'd0;
            cnt     <= 20'd0;
            cmd_key <= 2'd0;
            drop    <= 3'b000;
        end else begin
            // Set wins over the accept clear, so a same-edge re-press stays buffered.
            pending <= (pending & ~clr_mask) | key_pulse;
            drop    <= (drop_clr ? 3'b000 : drop) | drop_set;
            if (state == IDLE && |pending) begin
                cmd_key <= winner;
            end
            if (accept) begin
                ptr <= next_idx(cmd_key);
            end
            if (accept && HOLD_EN) begin
                cnt <= HOLD_LOAD;
            end else if (state == HOLD && cnt != 20'd0) begin
                cnt <= cnt - 20'd1;
            end
        end
    end

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// tb/tb_key_cmd_scheduler.sv - scoreboard bench for key_cmd_scheduler with hold-off 0, 4 and 8
module tb_key_cmd_scheduler;

    logic       clk;
    logic       rst_n;
    logic [2:0] key_pulse;
    logic       cmd_ready;
    logic       drop_clr;
    logic       cmd_valid [3];
    logic [1:0] cmd_key   [3];
    logic       busy      [3];
    logic [2:0] drop      [3];

    int compared;
    int mismatched;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        key_cmd_scheduler #(.HOLDOFF(g == 0 ? 0 : (g == 1 ? 4 : 8))) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .key_pulse (key_pulse),
            .cmd_ready (cmd_ready),
            .drop_clr  (drop_clr),
            .cmd_valid (cmd_valid[g]),
            .cmd_key   (cmd_key[g]),
            .busy      (busy[g]),
            .drop      (drop[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int hv(input int g);
        return (g == 0) ? 0 : ((g == 1) ? 4 : 8);
    endfunction

    // Reference model: time-stamped, edge n is the edge the current inputs will be sampled at.
    logic [2:0] m_pend [3];
    logic [2:0] m_drop [3];
    int         m_ptr [3];
    int         m_key [3];
    int         m_hold_end [3];
    bit         m_active [3];
    int         edge_n;
    bit         s_active [3];
    int         s_key [3];
    bit         s_busy [3];
    logic [2:0] s_drop [3];
    int         q0[$];
    int         q1[$];
    int         q2[$];
    bit         mon_en;

    function automatic int first_pending(input logic [2:0] p, input int ptr);
        for (int i = 0; i < 3; i++) begin
            if (p[(ptr + i) % 3]) return (ptr + i) % 3;
        end
        return -1;
    endfunction

    task automatic push_exp(input int g, input int k);
        case (g)
            0: q0.push_back(k);
            1: q1.push_back(k);
            default: q2.push_back(k);
        endcase
    endtask

    task automatic check(input string name, input int g, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s dut%0d at edge %0d: got %0d, expected %0d", name, g, edge_n, act, exp);
        end
    endtask

    task automatic model_step();
        logic [2:0] clr;
        logic [2:0] nd;
        bit         acc;
        edge_n++;
        for (int g = 0; g < 3; g++) begin
            s_active[g] = m_active[g];
            s_key[g]    = m_key[g];
            s_busy[g]   = m_active[g] || (m_hold_end[g] > edge_n - 1);
            s_drop[g]   = m_drop[g];
            if (!rst_n) begin
                m_pend[g] = 3'b000; m_drop[g] = 3'b000; m_ptr[g] = 0;
                m_key[g] = 0; m_active[g] = 1'b0; m_hold_end[g] = edge_n;
            end else begin
                acc = m_active[g] && cmd_ready;
                clr = acc ? 3'(1 << m_key[g]) : 3'b000;
                nd  = drop_clr ? 3'b000 : m_drop[g];
                for (int k = 0; k < 3; k++) begin
                    if (key_pulse[k] && m_pend[g][k] && !clr[k]) nd[k] = 1'b1;
                end
                if (acc) begin
                    push_exp(g, m_key[g]);
                    m_ptr[g]      = (m_key[g] + 1) % 3;
                    m_active[g]   = 1'b0;
                    m_hold_end[g] = edge_n + hv(g);
                end else if (!m_active[g] && m_hold_end[g] < edge_n && m_pend[g] != 3'b000) begin
                    m_active[g] = 1'b1;
                    m_key[g]    = first_pending(m_pend[g], m_ptr[g]);
                end
                m_pend[g] = (m_pend[g] & ~clr) | key_pulse;
                m_drop[g] = nd;
            end
        end
    endtask

    task automatic drive(input logic [2:0] kp, input logic rdy, input logic dc, input logic rn);
        key_pulse = kp;
        cmd_ready = rdy;
        drop_clr  = dc;
        rst_n     = rn;
        model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive(3'b000, rdy, 1'b0, 1'b1);
    endtask

    task automatic wait_valid0();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (cmd_valid[0]) begin
                found = 1'b1;
                break;
            end
            drive(3'b000, 1'b0, 1'b0, 1'b1);
        end
        check("wait_valid_timeout", 0, int'(found), 1);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int g = 0; g < 3; g++) begin
                int exp_k;
                check("cmd_valid", g, int'(cmd_valid[g]), int'(s_active[g]));
                if (s_active[g]) check("cmd_key", g, int'(cmd_key[g]), s_key[g]);
                check("busy", g, int'(busy[g]), int'(s_busy[g]));
                check("drop", g, int'(drop[g]), int'(s_drop[g]));
                if (rst_n && cmd_valid[g] && cmd_ready) begin
                    exp_k = -1;
                    case (g)
                        0: if (q0.size() > 0) exp_k = q0.pop_front();
                        1: if (q1.size() > 0) exp_k = q1.pop_front();
                        default: if (q2.size() > 0) exp_k = q2.pop_front();
                    endcase
                    check("accepted_key", g, int'(cmd_key[g]), exp_k);
                end
            end
        end
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        edge_n     = 0;
        mon_en     = 1'b0;
        for (int g = 0; g < 3; g++) begin
            m_pend[g] = 3'b000; m_drop[g] = 3'b000; m_ptr[g] = 0;
            m_key[g] = 0; m_hold_end[g] = 0; m_active[g] = 1'b0;
        end
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b1);

        // Single press, then simultaneous presses in two rounds, then 101 from ptr=1.
        drive(3'b010, 1'b1, 1'b0, 1'b1);
        idle(15, 1'b1);
        drive(3'b111, 1'b1, 1'b0, 1'b1);
        idle(40, 1'b1);
        drive(3'b111, 1'b1, 1'b0, 1'b1);
        idle(40, 1'b1);
        drive(3'b001, 1'b1, 1'b0, 1'b1);
        idle(15, 1'b1);
        drive(3'b101, 1'b1, 1'b0, 1'b1);
        idle(30, 1'b1);

        // Backpressure on key 2.
        drive(3'b100, 1'b0, 1'b0, 1'b1);
        wait_valid0();
        idle(10, 1'b0);
        idle(15, 1'b1);

        // Overflow while stalled, then a re-press exactly on the accept edge, then drop_clr.
        drive(3'b001, 1'b0, 1'b0, 1'b1);
        wait_valid0();
        idle(2, 1'b0);
        drive(3'b001, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b0);
        drive(3'b001, 1'b1, 1'b0, 1'b1);
        idle(25, 1'b1);
        drive(3'b000, 1'b1, 1'b1, 1'b1);
        idle(3, 1'b1);

        // Key-1 press landing inside the hold-off window.
        drive(3'b001, 1'b1, 1'b0, 1'b1);
        idle(3, 1'b1);
        drive(3'b010, 1'b1, 1'b0, 1'b1);
        idle(25, 1'b1);

        for (int i = 0; i < 2500; i++) begin
            logic [2:0] kp;
            kp[0] = ($urandom_range(0, 7) == 0);
            kp[1] = ($urandom_range(0, 7) == 0);
            kp[2] = ($urandom_range(0, 7) == 0);
            drive(kp, ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 199) != 0));
        end
        idle(40, 1'b1);

        // Reset while issuing with two keys buffered.
        drive(3'b011, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b0);
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        idle(20, 1'b1);
        idle(40, 1'b1);

        check("q_left", 0, q0.size(), 0);
        check("q_left", 1, q1.size(), 0);
        check("q_left", 2, q2.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
